cpu_sequencer: RTL and testbench

- Multi-cycle control unit that drives the datapath's CTRL_* inputs from the fetched opcode/fcode and owns the START/DONE run lifecycle.
- Holds the datapath in init for a fixed number of cycles, then decodes one instruction per cycle.
- Stalls the PC while a data-memory load completes.
- Provides cycle and instruction counters plus a watchdog timeout for the test harness.

---
 rtl/cpu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control sequencer for the datapath run lifecycle
module cpu_sequencer #(
    parameter int          INIT_CYCLES = 2,
    parameter int          MEM_LAT     = 1,
    parameter logic [15:0] MAX_CYCLES  = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        go,
    input  logic        done_in,
    input  logic [3:0]  opcode,
    input  logic        fcode,
    output logic        start_out,
    output logic        pc_hold,
    output logic        CTRL_branch_rel_nz,
    output logic        CTRL_branch_rel_z,
    output logic        CTRL_branch_abs,
    output logic        CTRL_reg_write_en,
    output logic        CTRL_reg_sel,
    output logic        CTRL_lut_in,
    output logic        CTRL_mem_to_reg,
    output logic        CTRL_alu_src,
    output logic        CTRL_alu_sc_in,
    output logic        CTRL_read_mem,
    output logic        CTRL_write_mem,
    output logic [2:0]  CTRL_alu_op,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycle_count,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_MEM, S_HALT
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  init_cnt, init_nxt;
    logic [2:0]  stall_cnt, stall_nxt;
    logic        cyc_inc, ins_inc, clr_cnt, set_timeout;
    logic        watchdog;

    assign watchdog = (cycle_count == MAX_CYCLES);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            init_cnt    <= '0;
            stall_cnt   <= '0;
            cycle_count <= '0;
            instr_count <= '0;
            timeout     <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_nxt;
            stall_cnt <= stall_nxt;
            if (clr_cnt) begin
                cycle_count <= '0;
                instr_count <= '0;
                timeout     <= 1'b0;
            end else begin
                if (cyc_inc && cycle_count != 16'hFFFF)
                    cycle_count <= cycle_count + 16'd1;
                if (ins_inc && instr_count != 16'hFFFF)
                    instr_count <= instr_count + 16'd1;
                if (set_timeout)
                    timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        init_nxt           = init_cnt;
        stall_nxt          = stall_cnt;
        cyc_inc            = 1'b0;
        ins_inc            = 1'b0;
        clr_cnt            = 1'b0;
        set_timeout        = 1'b0;
        start_out          = 1'b0;
        pc_hold            = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        CTRL_branch_rel_nz = 1'b0;
        CTRL_branch_rel_z  = 1'b0;
        CTRL_branch_abs    = 1'b0;
        CTRL_reg_write_en  = 1'b0;
        CTRL_reg_sel       = 1'b0;
        CTRL_lut_in        = 1'b0;
        CTRL_mem_to_reg    = 1'b0;
        CTRL_alu_src       = 1'b0;
        CTRL_alu_sc_in     = 1'b0;
        CTRL_read_mem      = 1'b0;
        CTRL_write_mem     = 1'b0;
        CTRL_alu_op        = 3'd0;

        case (state)
            S_IDLE, S_HALT: begin
                done = (state == S_HALT);
                if (go) begin
                    state_nxt = S_INIT;
                    clr_cnt   = 1'b1;
                    init_nxt  = 4'(INIT_CYCLES);
                end
            end
            S_INIT: begin
                start_out = 1'b1;
                busy      = 1'b1;
                init_nxt  = init_cnt - 4'd1;
                if (init_cnt <= 4'd1)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                // The watchdog cycle issues nothing, so the count stops at MAX_CYCLES.
                if (watchdog) begin
                    state_nxt   = S_HALT;
                    set_timeout = 1'b1;
                end else begin
                    cyc_inc = 1'b1;
                    ins_inc = (opcode != 4'hF) && (opcode != 4'h8);
                    case (opcode)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                            CTRL_alu_op       = opcode[2:0];
                            CTRL_reg_write_en = 1'b1;
                            CTRL_alu_sc_in    = fcode;
                        end
                        4'h7: begin
                            CTRL_alu_src      = 1'b1;
                            CTRL_reg_write_en = 1'b1;
                        end
                        4'h8: begin
                            CTRL_read_mem   = 1'b1;
                            CTRL_mem_to_reg = 1'b1;
                            pc_hold         = 1'b1;
                        end
                        4'h9: CTRL_write_mem    = 1'b1;
                        4'hA: CTRL_branch_rel_z  = 1'b1;
                        4'hB: CTRL_branch_rel_nz = 1'b1;
                        4'hC: begin
                            CTRL_branch_abs = 1'b1;
                            CTRL_lut_in     = fcode;
                        end
                        4'hD: CTRL_alu_op = 3'd1;
                        4'hE: begin
                            CTRL_reg_sel      = 1'b1;
                            CTRL_reg_write_en = 1'b1;
                        end
                        default: ;
                    endcase
                    if (done_in || opcode == 4'hF) begin
                        state_nxt = S_HALT;
                    end else if (opcode == 4'h8) begin
                        state_nxt = S_MEM;
                        stall_nxt = 3'(MEM_LAT);
                    end
                end
            end
            S_MEM: begin
                busy = 1'b1;
                if (watchdog) begin
                    state_nxt   = S_HALT;
                    set_timeout = 1'b1;
                end else begin
                    cyc_inc         = 1'b1;
                    CTRL_read_mem   = 1'b1;
                    CTRL_mem_to_reg = 1'b1;
                    if (stall_cnt != 3'd0) begin
                        pc_hold   = 1'b1;
                        stall_nxt = stall_cnt - 3'd1;
                    end else begin
                        CTRL_reg_write_en = 1'b1;
                        ins_inc           = 1'b1;
                        state_nxt         = S_RUN;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic CLK = 1'b0;
    logic reset_n, go, go2, done_in, fcode;
    logic [3:0] opcode;

    logic start_out, pc_hold, busy, done, timeout;
    logic nz, z, ab, we, sel, lut, m2r, src, sc, rd, wr;
    logic [2:0] aop;
    logic [15:0] cycle_count, instr_count;

    logic start2, hold2, busy2, done2, timeout2;
    logic nz2, z2, ab2, we2, sel2, lut2, m2r2, src2, sc2, rd2, wr2;
    logic [2:0] aop2;
    logic [15:0] cycle2, instr2;

    int total = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    cpu_sequencer #(.INIT_CYCLES(2), .MEM_LAT(1), .MAX_CYCLES(16'hFFFF)) dut (
        .CLK(CLK), .reset_n(reset_n), .go(go), .done_in(done_in),
        .opcode(opcode), .fcode(fcode), .start_out(start_out), .pc_hold(pc_hold),
        .CTRL_branch_rel_nz(nz), .CTRL_branch_rel_z(z), .CTRL_branch_abs(ab),
        .CTRL_reg_write_en(we), .CTRL_reg_sel(sel), .CTRL_lut_in(lut),
        .CTRL_mem_to_reg(m2r), .CTRL_alu_src(src), .CTRL_alu_sc_in(sc),
        .CTRL_read_mem(rd), .CTRL_write_mem(wr), .CTRL_alu_op(aop),
        .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    cpu_sequencer #(.INIT_CYCLES(2), .MEM_LAT(1), .MAX_CYCLES(16'd10)) dut_wd (
        .CLK(CLK), .reset_n(reset_n), .go(go2), .done_in(done_in),
        .opcode(opcode), .fcode(fcode), .start_out(start2), .pc_hold(hold2),
        .CTRL_branch_rel_nz(nz2), .CTRL_branch_rel_z(z2), .CTRL_branch_abs(ab2),
        .CTRL_reg_write_en(we2), .CTRL_reg_sel(sel2), .CTRL_lut_in(lut2),
        .CTRL_mem_to_reg(m2r2), .CTRL_alu_src(src2), .CTRL_alu_sc_in(sc2),
        .CTRL_read_mem(rd2), .CTRL_write_mem(wr2), .CTRL_alu_op(aop2),
        .busy(busy2), .done(done2), .timeout(timeout2),
        .cycle_count(cycle2), .instr_count(instr2)
    );

    // Order: nz z abs we sel lut m2r src sc rd wr op[2:0]
    wire [13:0] ctrl  = {nz, z, ab, we, sel, lut, m2r, src, sc, rd, wr, aop};
    wire [13:0] ctrl2 = {nz2, z2, ab2, we2, sel2, lut2, m2r2, src2, sc2, rd2, wr2, aop2};

    function automatic logic [13:0] c(input logic n_z, input logic b_z, input logic b_a,
                                      input logic w_e, input logic r_s, input logic l_i,
                                      input logic m_r, input logic a_s, input logic s_c,
                                      input logic r_m, input logic w_m, input logic [2:0] op);
        return {n_z, b_z, b_a, w_e, r_s, l_i, m_r, a_s, s_c, r_m, w_m, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        reset_n = 1'b0; go = 1'b0; go2 = 1'b0; done_in = 1'b0;
        opcode = 4'h0; fcode = 1'b0;
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(c(0,0,0,0,0,0,0,0,0,0,0,3'd0)));
        chk("rst_flags", {start_out, pc_hold, busy, done, timeout}, 5'b0);
        chk("rst_counts", {cycle_count, instr_count}, 32'h0);
        #12 reset_n = 1'b1;

        // Start-up: go in IDLE, then two INIT cycles
        step(); go = 1'b1; #1;
        chk("idle_busy", busy, 1'b0);
        step(); go = 1'b0; #1;
        chk("init1", {start_out, busy}, 2'b11);
        step(); #1;
        chk("init2", {start_out, busy}, 2'b11);
        step(); opcode = 4'h3; fcode = 1'b1; #1;
        chk("run_start", {start_out, busy}, 2'b01);
        chk("alu3_ctrl", 32'(ctrl), 32'(c(0,0,0,1,0,0,0,0,1,0,0,3'd3)));
        chk("alu3_hold", pc_hold, 1'b0);

        // Load with one stall cycle
        step(); opcode = 4'h8; fcode = 1'b0; #1;
        chk("alu3_counts", {cycle_count, instr_count}, {16'd1, 16'd1});
        chk("ld_run_ctrl", 32'(ctrl), 32'(c(0,0,0,0,0,0,1,0,0,1,0,3'd0)));
        chk("ld_run_hold", pc_hold, 1'b1);
        step(); #1;
        chk("ld_mem_stall_ctrl", 32'(ctrl), 32'(c(0,0,0,0,0,0,1,0,0,1,0,3'd0)));
        chk("ld_mem_stall_hold", pc_hold, 1'b1);
        step(); #1;
        chk("ld_mem_wr_ctrl", 32'(ctrl), 32'(c(0,0,0,1,0,0,1,0,0,1,0,3'd0)));
        chk("ld_mem_wr_hold", pc_hold, 1'b0);

        // done_in with BZ: branch issues, then HALT
        step(); opcode = 4'hA; done_in = 1'b1; #1;
        chk("ld_counts", {cycle_count, instr_count}, {16'd4, 16'd2});
        chk("bz_ctrl", 32'(ctrl), 32'(c(0,1,0,0,0,0,0,0,0,0,0,3'd0)));
        step(); done_in = 1'b0; opcode = 4'h0; #1;
        chk("halt_flags", {done, busy, pc_hold, start_out}, 4'b1000);
        chk("halt_ctrl", 32'(ctrl), 32'(c(0,0,0,0,0,0,0,0,0,0,0,3'd0)));
        chk("halt_counts", {cycle_count, instr_count}, {16'd5, 16'd3});
        step(); #1;
        chk("halt_frozen", {cycle_count, instr_count}, {16'd5, 16'd3});

        // Restart from HALT clears counters
        step(); go = 1'b1; #1;
        step(); go = 1'b0; #1;
        chk("restart_init", {start_out, done, cycle_count, instr_count}, {1'b1, 1'b0, 32'h0});
        step();
        step(); opcode = 4'h7; #1;
        chk("addi_ctrl", 32'(ctrl), 32'(c(0,0,0,1,0,0,0,1,0,0,0,3'd0)));
        step(); opcode = 4'h9; #1;
        chk("st_ctrl", 32'(ctrl), 32'(c(0,0,0,0,0,0,0,0,0,0,1,3'd0)));
        step(); opcode = 4'hC; fcode = 1'b1; #1;
        chk("jmp_ctrl", 32'(ctrl), 32'(c(0,0,1,0,0,1,0,0,0,0,0,3'd0)));
        step(); opcode = 4'hD; fcode = 1'b0; #1;
        chk("cmp_ctrl", 32'(ctrl), 32'(c(0,0,0,0,0,0,0,0,0,0,0,3'd1)));
        step(); opcode = 4'hE; #1;
        chk("setreg_ctrl", 32'(ctrl), 32'(c(0,0,0,1,1,0,0,0,0,0,0,3'd0)));
        step(); opcode = 4'hB; #1;
        chk("bnz_ctrl", 32'(ctrl), 32'(c(1,0,0,0,0,0,0,0,0,0,0,3'd0)));
        step(); opcode = 4'hF; #1;
        chk("hlt_ctrl", 32'(ctrl), 32'(c(0,0,0,0,0,0,0,0,0,0,0,3'd0)));
        chk("hlt_busy", busy, 1'b1);
        step(); opcode = 4'h0; #1;
        chk("hlt_done", done, 1'b1);
        chk("hlt_counts", {cycle_count, instr_count}, {16'd7, 16'd6});

        // Asynchronous reset in the middle of a load stall
        step(); go = 1'b1; #1;
        step(); go = 1'b0; #1;
        step();
        step(); opcode = 4'h8; #1;
        step(); #1;
        chk("mid_mem_hold", pc_hold, 1'b1);
        reset_n = 1'b0; #1;
        chk("async_ctrl", 32'(ctrl), 32'(c(0,0,0,0,0,0,0,0,0,0,0,3'd0)));
        chk("async_flags", {start_out, pc_hold, busy, done, timeout}, 5'b0);
        chk("async_counts", {cycle_count, instr_count}, 32'h0);
        step(); reset_n = 1'b1; #1;
        chk("post_rst1", {we, busy, done}, 3'b000);
        step(); #1;
        chk("post_rst2", {we, busy, done}, 3'b000);

        // Watchdog instance: ADD stream until MAX_CYCLES=10
        opcode = 4'h0; fcode = 1'b0;
        step(); go2 = 1'b1; #1;
        step(); go2 = 1'b0; #1;
        step();
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            chk($sformatf("wd_add%0d", i), {we2, busy2}, 2'b11);
        end
        step(); #1;
        chk("wd_fire_ctrl", 32'(ctrl2), 32'(c(0,0,0,0,0,0,0,0,0,0,0,3'd0)));
        chk("wd_fire_count", cycle2, 16'd10);
        step(); #1;
        chk("wd_halt", {done2, timeout2, busy2}, 3'b110);
        chk("wd_counts", {cycle2, instr2}, {16'd10, 16'd10});
        step(); go2 = 1'b1; #1;
        step(); go2 = 1'b0; #1;
        chk("wd_restart", {timeout2, start2, cycle2}, {1'b0, 1'b1, 16'd0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
